// File: rtl/ps2_key_event_fifo.sv
// ps2_key_event_fifo
//   Turns the scan-code-set-2 byte stream from the PS/2 receiver into key
//   events and queues them in a first-word-fall-through FIFO.
//   The decoder handles the E0 and F0 prefixes, filters typematic repeats of
//   the key currently held, and optionally reports break events.
//
// Ports
//   clk, reset     system clock, synchronous active-high reset
//   rx_done_tick   one-cycle strobe: rx_data holds a received byte
//   rx_data[7:0]   received byte
//   rd_en          pop the head event (ignored when empty)
//   clr_ovf        clear the sticky overflow flag
//   ev_data[9:0]   head event {brk, ext, code}; zero while empty
//   empty, full    FIFO status
//   count          number of stored events, 0..2**DEPTH_LOG2
//   overflow       sticky: an event was dropped because the FIFO was full
//   last_make[8:0] {ext, code} of the most recent successfully pushed make
module ps2_key_event_fifo #(
  parameter int unsigned DEPTH_LOG2       = 3,
  parameter bit          REPORT_BREAK     = 1'b0,
  parameter bit          TYPEMATIC_FILTER = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_done_tick,
  input  logic [7:0]            rx_data,
  input  logic                  rd_en,
  input  logic                  clr_ovf,
  output logic [9:0]            ev_data,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic [8:0]            last_make
);

  localparam int unsigned             DEPTH     = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]     DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]     CNT_ONE   = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0]   PTR_ONE   = DEPTH_LOG2'(1);

  typedef enum logic [1:0] {
    IDLE,
    GOT_E0,
    GOT_F0,
    GOT_E0F0
  } state_t;

  state_t state, state_nx;

  logic [9:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;

  logic       held_valid;
  logic [8:0] held_key;

  logic       is_ctrl;
  logic       ev_gen, ev_brk, ev_ext;
  logic [8:0] key;
  logic       held_hit, push_req, do_push, do_pop, ovf_set;

  // Bytes that abort any partial sequence; E1 (Pause) is not decoded.
  always_comb begin
    is_ctrl = 1'b0;
    case (rx_data)
      8'h00, 8'hAA, 8'hEE, 8'hE1,
      8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF: is_ctrl = 1'b1;
      default:                           is_ctrl = 1'b0;
    endcase
  end

  always_comb begin
    state_nx = state;
    ev_gen   = 1'b0;
    ev_brk   = 1'b0;
    ev_ext   = 1'b0;
    if (rx_done_tick) begin
      if (is_ctrl) begin
        state_nx = IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (rx_data == 8'hE0)      state_nx = GOT_E0;
            else if (rx_data == 8'hF0) state_nx = GOT_F0;
            else                       ev_gen   = 1'b1;
          end
          GOT_E0: begin
            if (rx_data == 8'hF0)      state_nx = GOT_E0F0;
            else if (rx_data == 8'hE0) state_nx = GOT_E0;
            else begin
              ev_gen   = 1'b1;
              ev_ext   = 1'b1;
              state_nx = IDLE;
            end
          end
          GOT_F0: begin
            ev_gen   = 1'b1;
            ev_brk   = 1'b1;
            state_nx = IDLE;
          end
          GOT_E0F0: begin
            ev_gen   = 1'b1;
            ev_brk   = 1'b1;
            ev_ext   = 1'b1;
            state_nx = IDLE;
          end
          default: state_nx = IDLE;
        endcase
      end
    end
  end

  assign key      = {ev_ext, rx_data};
  assign held_hit = held_valid && (held_key == key);
  assign push_req = ev_gen && (ev_brk ? REPORT_BREAK : !(TYPEMATIC_FILTER && held_hit));
  assign do_pop   = rd_en && !empty;
  // A pop on the same edge frees the slot, so a full FIFO still accepts.
  assign do_push  = push_req && (!full || do_pop);
  assign ovf_set  = push_req && full && !do_pop;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_CNT);
  assign ev_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= {ev_brk, key};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      last_make  <= '0;
      held_valid <= 1'b0;
      held_key   <= '0;
    end else begin
      state <= state_nx;

      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase

      if (ovf_set)      overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;

      if (do_push && !ev_brk) last_make <= key;

      // Tracker follows the decoded stream even when the push itself is lost.
      if (ev_gen) begin
        if (!ev_brk) begin
          if (!(TYPEMATIC_FILTER && held_hit)) begin
            held_key   <= key;
            held_valid <= 1'b1;
          end
        end else if (held_hit) begin
          held_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_event_fifo.sv
// Scoreboard bench for ps2_key_event_fifo: three instances share one byte
// stream (defaults; REPORT_BREAK=1; TYPEMATIC_FILTER=0). Stimulus pushes
// hand-computed events per instance; a monitor per instance pops and compares.
module tb_ps2_key_event_fifo;

  localparam bit RB_P [3] = '{1'b0, 1'b1, 1'b0};
  localparam bit TF_P [3] = '{1'b1, 1'b1, 1'b0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       rx_done_tick = 1'b0;
  logic [7:0] rx_data = '0;
  logic       clr_ovf = 1'b0;
  logic       stim_rd = 1'b0;
  logic       mon_en = 1'b0;

  logic [9:0] ev_data   [3];
  logic       empty     [3];
  logic       full      [3];
  logic       overflow  [3];
  logic [3:0] count     [3];
  logic [8:0] last_make [3];

  int vectors = 0;
  int errors  = 0;

  logic [9:0] q0 [$];
  logic [9:0] q1 [$];
  logic [9:0] q2 [$];

  task automatic chk(input string name, input int inst, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s dut%0d: got 0x%0h, expected 0x%0h", name, inst, act, exp);
    end
  endtask

  function automatic int qsize(input int i);
    case (i)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic qpop(input int i, output logic [9:0] v);
    case (i)
      0:       v = q0.pop_front();
      1:       v = q1.pop_front();
      default: v = q2.pop_front();
    endcase
  endtask

  task automatic exp3(input logic [9:0] a, input logic [9:0] b, input logic [9:0] c);
    q0.push_back(a);
    q1.push_back(b);
    q2.push_back(c);
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic rd_m = 1'b0;
    logic rd_en;
    assign rd_en = rd_m | stim_rd;

    ps2_key_event_fifo #(
      .DEPTH_LOG2      (3),
      .REPORT_BREAK    (RB_P[g]),
      .TYPEMATIC_FILTER(TF_P[g])
    ) u_dut (
      .clk         (clk),
      .reset       (reset),
      .rx_done_tick(rx_done_tick),
      .rx_data     (rx_data),
      .rd_en       (rd_en),
      .clr_ovf     (clr_ovf),
      .ev_data     (ev_data[g]),
      .empty       (empty[g]),
      .full        (full[g]),
      .count       (count[g]),
      .overflow    (overflow[g]),
      .last_make   (last_make[g])
    );

    always @(negedge clk) begin
      logic [9:0] e;
      if (mon_en && !empty[g]) begin
        if (qsize(g) == 0) begin
          chk("expected_queue_level", g, qsize(g), 1);
        end else begin
          qpop(g, e);
          chk("ev_data", g, int'(ev_data[g]), int'(e));
        end
        rd_m = 1'b1;
      end else begin
        rd_m = 1'b0;
      end
    end
  end

  task automatic send(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data      = b;
    rx_done_tick = 1'b1;
    @(posedge clk); #1;
    rx_done_tick = 1'b0;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
  endtask

  function automatic bit quiet();
    return (q0.size() == 0) && (q1.size() == 0) && (q2.size() == 0) &&
           empty[0] && empty[1] && empty[2];
  endfunction

  task automatic drain(input string name);
    int c = 0;
    while (c < 300 && !quiet()) begin
      @(posedge clk);
      c++;
    end
    #1;
    chk(name, 0, int'(quiet()), 1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("rst_empty", i, int'(empty[i]), 1);
      chk("rst_full", i, int'(full[i]), 0);
      chk("rst_count", i, int'(count[i]), 0);
      chk("rst_overflow", i, int'(overflow[i]), 0);
      chk("rst_last_make", i, int'(last_make[i]), 0);
      chk("rst_ev_data", i, int'(ev_data[i]), 0);
    end
    mon_en = 1'b1;

    // make / break of 1C
    exp3(10'h01C, 10'h01C, 10'h01C);
    q1.push_back(10'h21C);
    send(8'h1C); send(8'hF0); send(8'h1C);
    drain("drain_seq1");
    for (int i = 0; i < 3; i++) chk("last_make_seq1", i, int'(last_make[i]), 'h01C);

    // extended make / break
    exp3(10'h175, 10'h175, 10'h175);
    q1.push_back(10'h375);
    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
    drain("drain_seq2");
    for (int i = 0; i < 3; i++) chk("last_make_seq2", i, int'(last_make[i]), 'h175);

    // typematic repeats
    exp3(10'h01C, 10'h01C, 10'h01C);
    exp3(10'h01C, 10'h21C, 10'h01C);
    q1.push_back(10'h01C);
    q2.push_back(10'h01C);
    q2.push_back(10'h01C);
    send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C); send(8'h1C);
    drain("drain_seq3");

    // reset after a lone E0 discards the prefix
    send(8'hE0);
    pulse_reset();
    for (int i = 0; i < 3; i++) chk("mid_rst_count", i, int'(count[i]), 0);
    exp3(10'h075, 10'h075, 10'h075);
    send(8'h75);
    drain("drain_rst");
    for (int i = 0; i < 3; i++) chk("last_make_rst", i, int'(last_make[i]), 'h075);

    // control byte between E0 and code aborts the prefix
    exp3(10'h074, 10'h074, 10'h074);
    send(8'hE0); send(8'hFA); send(8'h74);
    drain("drain_ctrl_abort");

    // control bytes alone produce nothing
    send(8'hFA); send(8'hAA);
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("ctrl_empty", i, int'(empty[i]), 1);
      chk("ctrl_count", i, int'(count[i]), 0);
    end

    // fill past capacity with no reads
    mon_en = 1'b0;
    send(8'h15); send(8'h1D); send(8'h24); send(8'h2D); send(8'h2C);
    send(8'h35); send(8'h3C); send(8'h43); send(8'h44);
    for (int i = 0; i < 3; i++) begin
      chk("ovf_full", i, int'(full[i]), 1);
      chk("ovf_count", i, int'(count[i]), 8);
      chk("ovf_flag", i, int'(overflow[i]), 1);
      chk("ovf_head", i, int'(ev_data[i]), 'h015);
      chk("ovf_last_make", i, int'(last_make[i]), 'h043);
    end

    @(posedge clk); #1 clr_ovf = 1'b1;
    @(posedge clk); #1 clr_ovf = 1'b0;
    for (int i = 0; i < 3; i++) chk("clr_ovf", i, int'(overflow[i]), 0);

    // push and pop together while full
    @(posedge clk); #1;
    rx_data = 8'h4B; rx_done_tick = 1'b1; stim_rd = 1'b1;
    @(posedge clk); #1;
    rx_done_tick = 1'b0; stim_rd = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("pp_count", i, int'(count[i]), 8);
      chk("pp_full", i, int'(full[i]), 1);
      chk("pp_overflow", i, int'(overflow[i]), 0);
      chk("pp_head", i, int'(ev_data[i]), 'h01D);
      chk("pp_last_make", i, int'(last_make[i]), 'h04B);
    end

    // overflow set beats clr_ovf in the same cycle
    @(posedge clk); #1;
    rx_data = 8'h4C; rx_done_tick = 1'b1; clr_ovf = 1'b1;
    @(posedge clk); #1;
    rx_done_tick = 1'b0; clr_ovf = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("set_wins_ovf", i, int'(overflow[i]), 1);
      chk("set_wins_count", i, int'(count[i]), 8);
      chk("set_wins_last_make", i, int'(last_make[i]), 'h04B);
    end
    @(posedge clk); #1 clr_ovf = 1'b1;
    @(posedge clk); #1 clr_ovf = 1'b0;

    exp3(10'h01D, 10'h01D, 10'h01D);
    exp3(10'h024, 10'h024, 10'h024);
    exp3(10'h02D, 10'h02D, 10'h02D);
    exp3(10'h02C, 10'h02C, 10'h02C);
    exp3(10'h035, 10'h035, 10'h035);
    exp3(10'h03C, 10'h03C, 10'h03C);
    exp3(10'h043, 10'h043, 10'h043);
    exp3(10'h04B, 10'h04B, 10'h04B);
    mon_en = 1'b1;
    drain("drain_full");
    for (int i = 0; i < 3; i++) begin
      chk("final_count", i, int'(count[i]), 0);
      chk("final_overflow", i, int'(overflow[i]), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/ps2_key_event_fifo.md
Name: ps2_key_event_fifo

Overview:
Decodes the scan-code-set-2 byte stream from the PS/2 receiver into key events and buffers them in a parametrised FIFO. Each event records make/break, extended (E0) and the 8-bit key code. The block sits between receptor_teclado_ps2 and the consumer, such as keycode_to_ascii or a CPU/display FSM. It adds prefix decoding, typematic (auto-repeat) filtering, optional break reporting, FIFO buffering and overflow detection.

Parameters:
DEPTH_LOG2, 3, FIFO depth is 2**DEPTH_LOG2 events.
REPORT_BREAK, 0, 1 pushes break events; 0 discards them after decode.
TYPEMATIC_FILTER, 1, 1 drops repeated make events of the key currently held.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
rx_done_tick  in  1  one-cycle strobe: rx_data is a valid received byte
rx_data  in  8  received byte (receiver dout[8:1])
rd_en  in  1  pop head event; ignored when empty
clr_ovf  in  1  clears overflow
ev_data  out  10  head event {brk, ext, code[7:0]}; valid only when empty=0
empty  out  1  FIFO empty
full  out  1  FIFO full
count  out  DEPTH_LOG2+1  events stored, 0..2**DEPTH_LOG2
overflow  out  1  sticky: an event was lost because the FIFO was full
last_make  out  9  {ext, code} of the most recent pushed make event

Behaviour:
- Reset: FSM=IDLE, FIFO pointers=0, count=0, empty=1, full=0, overflow=0, last_make=0, held tracker invalid, ev_data=0.
- Decoder FSM states: IDLE, GOT_E0, GOT_F0, GOT_E0F0. It advances only on cycles with rx_done_tick=1.
- IDLE: E0 goes to GOT_E0. F0 goes to GOT_F0. Any other byte generates make{ext=0} and stays in IDLE.
- GOT_E0: F0 goes to GOT_E0F0. E0 stays in GOT_E0. Any other byte generates make{ext=1} and goes to IDLE.
- GOT_F0: any byte generates break{ext=0} and goes to IDLE. GOT_E0F0: any byte generates break{ext=1} and goes to IDLE.
- Control bytes 00, AA, EE, FA, FC, FD, FE, FF: in any state they return the FSM to IDLE and generate no event. E1 (Pause) is not decoded; it is treated as a control byte.
- Typematic filter: a held register holds {ext,code} plus a valid bit.
  - Make equal to held while valid: dropped when TYPEMATIC_FILTER=1.
  - Otherwise the make is pushed and held is set to it.
  - Break whose {ext,code} equals held clears valid. Breaks of other keys leave held unchanged.
  - The filter updates even when the push is lost to overflow.
- Break events are pushed only when REPORT_BREAK=1.
- Push timing: the event is written on the clock edge ending the rx_done_tick cycle. empty deasserts and count increments in the next cycle. Decode-to-visible latency is 1 clock.
- Read: first-word-fall-through. ev_data always shows the head entry. rd_en=1 with empty=0 pops on that edge, and the next entry (if any) appears the following cycle.
- Simultaneous push and pop:
  - Non-empty FIFO: both occur and count is unchanged.
  - Empty FIFO: only the push occurs.
  - Full FIFO: both occur, nothing is lost and overflow stays unchanged.
- Push while full without a pop: the event is dropped and overflow is set to 1. overflow clears only on reset or clr_ovf=1. If clr_ovf and an overflow occur in the same cycle, set wins.
- Pointers are DEPTH_LOG2 bits wide and wrap modulo the depth. full = (count==2**DEPTH_LOG2). empty = (count==0).
- last_make updates on the same edge as a successful make push.
- Reset mid-sequence (for example after E0, before the code byte): the FSM returns to IDLE and the partial sequence is discarded. Reset has priority over all inputs.

Test Plan:
- Bytes 1C, F0, 1C with defaults -> one event 0x01C; last_make=0x01C; the break produces no event. With REPORT_BREAK=1, the events are 0x01C then 0x21C.
- Bytes E0, 75, E0, F0, 75 with REPORT_BREAK=1 -> events 0x175, 0x375; FSM ends in IDLE.
- Bytes 1C, 1C, 1C (typematic), F0, 1C, 1C -> exactly two 0x01C events; with TYPEMATIC_FILTER=0, four.
- Nine distinct makes (15,1D,24,2D,2C,35,3C,43,44) with no reads, DEPTH_LOG2=3 -> full=1, count=8, overflow=1, head=0x015; pop 8 gives order 15..43 with 44 lost; clr_ovf clears overflow.
- Full FIFO plus simultaneous push and rd_en -> count stays 8, overflow=0, new event becomes the tail.
- Bytes E0, then reset, then 75 -> event 0x075 (ext=0). Bytes FA and AA alone -> no events, empty=1.
